// File: rtl/memgame_sequencer.sv
// Sequence-memory game controller: builds a pattern table from a seed, plays patterns 0..level
// on the LEDs, then checks the player's switch entries against the table.
module memgame_sequencer #(
   parameter int unsigned WIDTH        = 10,
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned SHOW_TICKS   = 1,
   parameter int unsigned GAP_TICKS    = 1,
   parameter int unsigned RESULT_TICKS = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick,
   input  logic [WIDTH-1:0]         seed,
   input  logic                     start_p,
   input  logic                     confirm_p,
   input  logic [WIDTH-1:0]         sw,
   output logic [WIDTH-1:0]         led,
   output logic [$clog2(DEPTH)-1:0] show_idx,
   output logic [$clog2(DEPTH)-1:0] player_level,
   output logic [$clog2(DEPTH)-1:0] confirm_level,
   output logic [1:0]               result,
   output logic                     busy
);

   localparam int unsigned IdxW = $clog2(DEPTH);
   localparam int unsigned MaxTicks =
      (SHOW_TICKS > GAP_TICKS) ? ((SHOW_TICKS > RESULT_TICKS) ? SHOW_TICKS : RESULT_TICKS)
                               : ((GAP_TICKS > RESULT_TICKS) ? GAP_TICKS : RESULT_TICKS);
   localparam int unsigned TickW = $clog2(MaxTicks + 1);

   localparam logic [IdxW-1:0]  LastIdx    = IdxW'(DEPTH - 1);
   localparam logic [TickW-1:0] ShowLast   = TickW'(SHOW_TICKS - 1);
   localparam logic [TickW-1:0] GapLast    = TickW'(GAP_TICKS - 1);
   localparam logic [TickW-1:0] ResultLast = TickW'(RESULT_TICKS - 1);

   localparam logic [1:0] ResNone = 2'b00;
   localparam logic [1:0] ResPass = 2'b01;
   localparam logic [1:0] ResFail = 2'b10;
   localparam logic [1:0] ResWin  = 2'b11;

   typedef enum logic [2:0] {
      StIdle, StSeed, StShow, StGap, StInput, StPass, StFail, StWin
   } state_e;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   show_idx_q, show_idx_d;
   logic [IdxW-1:0]   player_level_q, player_level_d;
   logic [IdxW-1:0]   confirm_level_q, confirm_level_d;
   logic [IdxW-1:0]   seed_idx_q, seed_idx_d;
   logic [1:0]        result_q, result_d;
   logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
   logic [WIDTH-1:0]  led_q, led_d;
   logic              busy_q, busy_d;

   logic [WIDTH-1:0]  levels_q [DEPTH];
   logic              tbl_we;
   logic [IdxW-1:0]   tbl_waddr;
   logic [WIDTH-1:0]  tbl_wdata;

   logic [IdxW-1:0]   seed_prev_idx;
   logic [WIDTH-1:0]  seed_prev, seed_next;
   logic              timed, tick_done;
   logic [TickW-1:0]  tick_limit;

   assign seed_prev_idx = seed_idx_q - IdxW'(1);
   assign seed_prev     = levels_q[seed_prev_idx];
   assign seed_next     = seed_prev ^ (seed_prev << 1) ^ (seed_prev << 5);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= StIdle;
         show_idx_q      <= '0;
         player_level_q  <= '0;
         confirm_level_q <= '0;
         seed_idx_q      <= '0;
         result_q        <= ResNone;
         tick_cnt_q      <= '0;
         led_q           <= '0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         show_idx_q      <= show_idx_d;
         player_level_q  <= player_level_d;
         confirm_level_q <= confirm_level_d;
         seed_idx_q      <= seed_idx_d;
         result_q        <= result_d;
         tick_cnt_q      <= tick_cnt_d;
         led_q           <= led_d;
         busy_q          <= busy_d;
      end
   end

   // Table contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge clk) begin
      if (tbl_we) begin
         levels_q[tbl_waddr] <= tbl_wdata;
      end
   end

   always_comb begin
      state_d         = state_q;
      show_idx_d      = show_idx_q;
      player_level_d  = player_level_q;
      confirm_level_d = confirm_level_q;
      seed_idx_d      = seed_idx_q;
      result_d        = result_q;
      tick_cnt_d      = tick_cnt_q;
      tbl_we          = 1'b0;
      tbl_waddr       = '0;
      tbl_wdata       = '0;

      tick_limit = ResultLast;
      if (state_q == StShow) begin
         tick_limit = ShowLast;
      end else if (state_q == StGap) begin
         tick_limit = GapLast;
      end
      timed     = state_q inside {StShow, StGap, StPass, StFail};
      tick_done = timed && tick && (tick_cnt_q == tick_limit);
      if (timed && tick) begin
         tick_cnt_d = tick_cnt_q + 1'b1;
      end

      unique case (state_q)
         StIdle, StWin: begin
            if (start_p) begin
               tbl_we          = 1'b1;
               tbl_wdata       = (seed == '0) ? WIDTH'(1) : seed;
               player_level_d  = '0;
               confirm_level_d = '0;
               show_idx_d      = '0;
               seed_idx_d      = IdxW'(1);
               result_d        = ResNone;
               state_d         = StSeed;
            end
         end
         StSeed: begin
            tbl_we     = 1'b1;
            tbl_waddr  = seed_idx_q;
            tbl_wdata  = seed_next;
            seed_idx_d = seed_idx_q + 1'b1;
            if (seed_idx_q == LastIdx) begin
               show_idx_d = '0;
               state_d    = StShow;
            end
         end
         StShow: begin
            if (tick_done) begin
               state_d = StGap;
            end
         end
         StGap: begin
            if (tick_done) begin
               if (show_idx_q == player_level_q) begin
                  show_idx_d      = '0;
                  confirm_level_d = '0;
                  state_d         = StInput;
               end else begin
                  show_idx_d = show_idx_q + 1'b1;
                  state_d    = StShow;
               end
            end
         end
         StInput: begin
            if (confirm_p) begin
               if (sw != levels_q[confirm_level_q]) begin
                  player_level_d  = '0;
                  confirm_level_d = '0;
                  result_d        = ResFail;
                  state_d         = StFail;
               end else if (confirm_level_q < player_level_q) begin
                  confirm_level_d = confirm_level_q + 1'b1;
                  result_d        = ResNone;
               end else if (player_level_q == LastIdx) begin
                  result_d = ResWin;
                  state_d  = StWin;
               end else begin
                  player_level_d  = player_level_q + 1'b1;
                  confirm_level_d = '0;
                  result_d        = ResPass;
                  state_d         = StPass;
               end
            end
         end
         StPass, StFail: begin
            if (tick_done) begin
               show_idx_d = '0;
               state_d    = StShow;
            end
         end
      endcase

      if (state_d != state_q) begin
         tick_cnt_d = '0;
      end
   end

   // led follows the registered state, so it lags the state change by one clk.
   always_comb begin
      led_d  = '0;
      if (state_q == StShow) begin
         led_d = levels_q[show_idx_q];
      end
      busy_d = state_d inside {StSeed, StShow, StGap, StPass, StFail};
   end

   assign led           = led_q;
   assign show_idx      = show_idx_q;
   assign player_level  = player_level_q;
   assign confirm_level = confirm_level_q;
   assign result        = result_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_memgame_sequencer.sv
// Scoreboard bench for memgame_sequencer: a game-level model queues expected LED patterns and
// status snapshots; monitors pop and compare when the DUT shows a pattern or samples a key.
module tb_memgame_sequencer;

   localparam int unsigned W = 10;
   localparam int unsigned D = 16;

   logic         clk = 1'b0;
   logic         rst, tick, start_p, confirm_p;
   logic [W-1:0] seed, sw, led;
   logic [3:0]   show_idx, player_level, confirm_level;
   logic [1:0]   result;
   logic         busy;

   memgame_sequencer #(
      .WIDTH(W), .DEPTH(D), .SHOW_TICKS(1), .GAP_TICKS(1), .RESULT_TICKS(2)
   ) dut (
      .clk(clk), .rst(rst), .tick(tick), .seed(seed), .start_p(start_p),
      .confirm_p(confirm_p), .sw(sw), .led(led), .show_idx(show_idx),
      .player_level(player_level), .confirm_level(confirm_level), .result(result), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] pat;
      logic [3:0]   idx;
   } show_t;

   typedef struct packed {
      logic [1:0] res;
      logic [3:0] pl;
      logic [3:0] cl;
      logic       busy;
   } stat_t;

   show_t exp_show_q[$];
   stat_t exp_stat_q[$];
   int    n_vec = 0;
   int    n_err = 0;
   bit    tick_en = 1'b0;

   // Game-level reference state.
   logic [W-1:0] m_table [D];
   int           m_pl, m_cl;
   logic [1:0]   m_res;
   bit           m_win;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   task automatic finish_run();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_seed(logic [W-1:0] s);
      int unsigned v;
      m_table[0] = (s == '0) ? W'(1) : s;
      for (int i = 1; i < D; i++) begin
         v = 32'(m_table[i-1]);
         v = (v ^ (v * 2) ^ (v * 32)) % (1 << W);
         m_table[i] = W'(v);
      end
   endfunction

   function automatic void push_play();
      for (int i = 0; i <= m_pl; i++) exp_show_q.push_back('{pat: m_table[i], idx: 4'(i)});
   endfunction

   function automatic void push_stat(bit b);
      exp_stat_q.push_back('{res: m_res, pl: 4'(m_pl), cl: 4'(m_cl), busy: b});
   endfunction

   task automatic wait_input(string where);
      int n = 0;
      while (busy === 1'b1 && n < 3000) begin
         step();
         n++;
      end
      if (busy !== 1'b0) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_input_%s: busy=%b after %0d clks, expected 0", where, busy, n);
         finish_run();
      end
      check("playback_drained", exp_show_q.size(), 0);
   endtask

   task automatic do_start(logic [W-1:0] s);
      seed    = s;
      start_p = 1'b1;
      model_seed(s);
      m_pl  = 0;
      m_cl  = 0;
      m_res = 2'b00;
      m_win = 1'b0;
      push_stat(1'b1);
      push_play();
      step();
      start_p = 1'b0;
   endtask

   task automatic do_confirm(logic [W-1:0] s, bit with_start);
      bit b;
      if (s != m_table[m_cl]) begin
         m_pl = 0; m_cl = 0; m_res = 2'b10; b = 1'b1;
         push_play();
      end else if (m_cl < m_pl) begin
         m_cl++; m_res = 2'b00; b = 1'b0;
      end else if (m_pl == D - 1) begin
         m_res = 2'b11; m_win = 1'b1; b = 1'b0;
      end else begin
         m_pl++; m_cl = 0; m_res = 2'b01; b = 1'b1;
         push_play();
      end
      push_stat(b);
      sw        = s;
      confirm_p = 1'b1;
      start_p   = with_start;
      seed      = W'($urandom);
      step();
      confirm_p = 1'b0;
      start_p   = 1'b0;
   endtask

   // Pulse keys that must be ignored in the current state; status must not move.
   task automatic poke(bit st, bit cf, logic [W-1:0] s, bit exp_busy);
      push_stat(exp_busy);
      sw        = s;
      seed      = W'($urandom);
      start_p   = st;
      confirm_p = cf;
      step();
      start_p   = 1'b0;
      confirm_p = 1'b0;
   endtask

   task automatic rand_confirm();
      int unsigned r = $urandom_range(0, 99);
      logic [W-1:0] v = m_table[m_cl];
      if (r < 12) v = v ^ W'($urandom_range(1, (1 << W) - 1));
      do_confirm(v, (r % 7) == 0);
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_led"}, led, 0);
      check({tag, "_show_idx"}, show_idx, 0);
      check({tag, "_player_level"}, player_level, 0);
      check({tag, "_confirm_level"}, confirm_level, 0);
      check({tag, "_result"}, result, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tick = tick_en && ($urandom_range(0, 2) == 0);
      end
   end

   // Pattern monitor: each new nonzero led value is one displayed pattern.
   initial begin
      logic [W-1:0] prev = '0;
      show_t e;
      forever begin
         @(negedge clk);
         if (led !== prev && led !== '0) begin
            if (exp_show_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL led_unexpected: got 0x%0h, expected no pattern", led);
            end else begin
               e = exp_show_q.pop_front();
               check("led_pattern", led, e.pat);
               check("show_idx_at_pattern", show_idx, e.idx);
            end
         end
         prev = led;
      end
   end

   // Status monitor: after every clk in which a key was sampled, compare the status outputs.
   initial begin
      stat_t e;
      forever begin
         @(posedge clk);
         if (rst === 1'b0 && (start_p === 1'b1 || confirm_p === 1'b1)) begin
            @(negedge clk);
            if (exp_stat_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL status_unexpected: got result=%0d, expected no key event", result);
            end else begin
               e = exp_stat_q.pop_front();
               check("result", result, e.res);
               check("player_level", player_level, e.pl);
               check("confirm_level", confirm_level, e.cl);
               check("busy", busy, e.busy);
            end
         end
      end
   end

   initial begin
      #900000;
      n_vec++;
      n_err++;
      $display("FAIL watchdog: got timeout, expected completion");
      finish_run();
   end

   initial begin
      int n;
      rst = 1'b1; start_p = 1'b0; confirm_p = 1'b0; seed = '0; sw = '0;
      repeat (3) step();
      check_reset_outputs("reset");
      rst = 1'b0;
      step();

      // Game A: seed 1, ticks held off so SEED length and SHOW entry can be timed.
      do_start(W'(1));
      repeat (15) step();
      check("seed_led_quiet", led, 0);
      check("seed_busy", busy, 1);
      step();
      check("first_show_led", led, m_table[0]);
      poke(1'b0, 1'b1, m_table[0], 1'b1);
      poke(1'b1, 1'b0, W'(0), 1'b1);
      check("show_hold_led", led, m_table[0]);
      tick_en = 1'b1;
      wait_input("a0");
      poke(1'b1, 1'b0, W'(0), 1'b0);
      do_confirm(m_table[0], 1'b0);
      wait_input("a1");
      do_confirm(m_table[0], 1'b0);
      do_confirm(W'(10'h3FF), 1'b0);
      wait_input("a2");
      do_confirm(m_table[0], 1'b1);
      repeat (6) begin
         wait_input("a3");
         rand_confirm();
      end
      wait_input("a4");
      do_confirm(m_table[m_cl] ^ W'(10'h200), 1'b0);
      n = 0;
      while (led === '0 && n < 3000) begin
         step();
         n++;
      end
      check("replay_seen", (led !== '0), 1);
      rst = 1'b1;
      step();
      check_reset_outputs("mid_show_rst");
      rst = 1'b0;
      exp_show_q.delete();
      step();

      // Game B: seed 0 behaves as seed 1; play every level correctly to WIN.
      do_start(W'(0));
      while (!m_win) begin
         wait_input("b");
         do_confirm(m_table[m_cl], 1'b0);
      end
      repeat (5) step();
      poke(1'b0, 1'b1, W'(0), 1'b0);
      check("win_led", led, 0);
      check("win_result_hold", result, 2'b11);

      // Game C: restart from WIN with a random seed and mixed answers.
      do_start(W'($urandom));
      repeat (30) begin
         if (!m_win) begin
            wait_input("c");
            rand_confirm();
         end
      end
      if (!m_win) wait_input("end");
      repeat (2) step();
      check("status_drained", exp_stat_q.size(), 0);
      finish_run();
   end

endmodule

// File: doc/memgame_sequencer.md
Name: memgame_sequencer

Overview:
Synchronous game controller for the sequence memory game. It generates the pseudo-random pattern table from a seed and plays the first N patterns on the LEDs. It then checks the player's switch entries against the table and advances or resets the level, reporting pass, fail or win. It sits between the debounced KEY/SW inputs and the LEDR/HEX display drivers, replacing the per-button edge-clocked logic with one clocked FSM.

Parameters:
WIDTH, 10, pattern width in bits; equals the LED/switch count
DEPTH, 16, number of patterns (levels) in the table; power of 2
SHOW_TICKS, 1, ticks each pattern stays lit during playback
GAP_TICKS, 1, blank ticks after each pattern
RESULT_TICKS, 2, ticks the PASS/FAIL state holds before replay

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tick  in  1  one-clk pulse from the slow game-rate divider; paces SHOW/GAP/PASS/FAIL
seed  in  WIDTH  free-running counter value, sampled at game start
start_p  in  1  one-clk pulse, debounced start key
confirm_p  in  1  one-clk pulse, debounced confirm key
sw  in  WIDTH  player's switch entry
led  out  WIDTH  pattern shown during SHOW, otherwise 0
show_idx  out  log2(DEPTH)  index of the pattern being shown
player_level  out  log2(DEPTH)  current level; level L requires patterns 0..L
confirm_level  out  log2(DEPTH)  index the player is entering next
result  out  2  00 none, 01 pass, 10 fail, 11 win
busy  out  1  high in SEED/SHOW/GAP/PASS/FAIL; low in IDLE/INPUT/WIN

Behaviour:
- Reset: state=IDLE; led=0, show_idx=0, player_level=0, confirm_level=0, result=00, busy=0, tick counter=0. Table contents are don't-care.
- IDLE: start_p loads levels[0]=seed, or 1 if seed==0. Clears levels, result and counters, then goes to SEED.
- SEED: fills one entry per clk. levels[i]=levels[i-1]^(levels[i-1]<<1)^(levels[i-1]<<5), truncated to WIDTH, for i=1..DEPTH-1. Lasts DEPTH-1 clks, then goes to SHOW with show_idx=0. Ignores tick, start_p and confirm_p.
- SHOW: led=levels[show_idx]. After SHOW_TICKS ticks, goes to GAP.
- GAP: led=0. After GAP_TICKS ticks: if show_idx==player_level, goes to INPUT with show_idx=0 and confirm_level=0; else show_idx++ and returns to SHOW.
- Tick counter counts ticks within a timed state. It resets to 0 on every state change. Ticks arriving in the entry clk of a state count.
- INPUT: led=0. confirm_p compares sw with levels[confirm_level]:
  - mismatch: player_level=0, confirm_level=0, result=10, go to FAIL;
  - match with confirm_level<player_level: confirm_level++, result=00, stay in INPUT;
  - match with confirm_level==player_level and player_level==DEPTH-1: result=11, go to WIN;
  - match, final entry otherwise: player_level++, confirm_level=0, result=01, go to PASS.
- PASS/FAIL: led=0. After RESULT_TICKS ticks, go to SHOW with show_idx=0, replaying from pattern 0. result holds its value until the next evaluated confirm or a new game.
- WIN: outputs frozen. start_p starts a new game exactly as from IDLE.
- start_p is ignored in SEED, SHOW, GAP, INPUT, PASS and FAIL.
- confirm_p is ignored outside INPUT.
- start_p and confirm_p in the same clk in INPUT: the confirm is evaluated and the start is ignored.
- rst has priority over all inputs in any state, including mid-SEED and mid-SHOW.
- All outputs are registered; led changes the clk after the state transition.

Test Plan:
- Reset, then start_p with seed=0x001 -> busy=1; after 15 clks levels[0..2]=0x001,0x023,0x005; SHOW entered with led=0x001 one clk later.
- seed=0x000 -> levels[0]=0x001; sequence identical to the seed=0x001 case.
- Level 0, in INPUT: sw=0x001, confirm_p -> result=01, player_level=1. After 2 ticks SHOW replays 0x001, then 0 (gap), then 0x023, then 0 (gap), then INPUT.
- Level 1, sw=0x001 then sw=0x3FF with confirm_p each -> confirm_level goes 0→1, result=00; second confirm gives result=10, player_level=0, confirm_level=0, FAIL for 2 ticks.
- confirm_p during SHOW and start_p during INPUT -> no change to any output; simultaneous start_p+confirm_p in INPUT -> only the confirm takes effect.
- Play 16 correct levels -> result=11, state WIN, busy=0. start_p then reseeds; rst asserted mid-SHOW returns all outputs to reset values the next clk.
